csi2_stat_sched: RTL

Statistics scheduler for the CSI-2 receiver. It sequences the statistics accumulator by defining measurement windows of N frames. At each window end it latches the accumulator's seven counters into shadow registers and pulses the accumulator's clear input. Software reads the shadow registers through a registered read port, so the counters it sees always cover exactly one window.

---
 rtl/csi2_stat_sched_if.sv | 22 ++
 rtl/csi2_stat_sched.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/csi2_stat_sched_if.sv
// rtl/csi2_stat_sched_if.sv - shadow register read port and snapshot handshake of csi2_stat_sched
interface csi2_stat_sched_if;
  logic        rd_en_i;
  logic [2:0]  rd_addr_i;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        snap_valid_o;
  logic        snap_ack_i;
  logic        snap_ovf_o;

  // scheduler side
  modport slave (
    input  rd_en_i, rd_addr_i, snap_ack_i,
    output rd_data_o, rd_valid_o, snap_valid_o, snap_ovf_o
  );

  // software / consumer side
  modport master (
    output rd_en_i, rd_addr_i, snap_ack_i,
    input  rd_data_o, rd_valid_o, snap_valid_o, snap_ovf_o
  );
endinterface

// File: rtl/csi2_stat_sched.sv
// rtl/csi2_stat_sched.sv - frame-window statistics scheduler with shadow snapshot registers
module csi2_stat_sched #(
  parameter int WIN_W = 16
) (
  input  logic               clk_i,
  input  logic               srst_i,
  input  logic               enable_i,
  input  logic [WIN_W-1:0]   window_frames_i,
  input  logic               sof_i,
  input  logic               manual_snap_i,
  input  logic [31:0]        header_err_cnt_i,
  input  logic [31:0]        corr_header_err_cnt_i,
  input  logic [31:0]        crc_err_cnt_i,
  input  logic [31:0]        max_ln_per_frame_i,
  input  logic [31:0]        min_ln_per_frame_i,
  input  logic [31:0]        max_px_per_ln_i,
  input  logic [31:0]        min_px_per_ln_i,
  output logic               clear_stat_o,
  csi2_stat_sched_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SYNC, COUNT, SNAP} state_e;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             capture_en_q, capture_en_d;
  logic             clear_q;
  logic [31:0]      snap_cnt_q;
  logic [31:0]      shadow_q [7];
  logic [31:0]      stat_in [7];
  logic [WIN_W:0]   win_eff;
  logic [WIN_W:0]   frame_next;
  logic             window_done;
  logic             capture;
  logic             snap_valid_q;
  logic             snap_ovf_q;
  logic             rd_valid_q;
  logic [31:0]      rd_data_q;
  logic [31:0]      rd_mux;

  assign stat_in[0] = header_err_cnt_i;
  assign stat_in[1] = corr_header_err_cnt_i;
  assign stat_in[2] = crc_err_cnt_i;
  assign stat_in[3] = max_ln_per_frame_i;
  assign stat_in[4] = min_ln_per_frame_i;
  assign stat_in[5] = max_px_per_ln_i;
  assign stat_in[6] = min_px_per_ln_i;

  // One extra bit keeps the compare exact even when the window is the full counter range.
  assign win_eff     = (window_frames_i == '0) ? (WIN_W+1)'(1) : {1'b0, window_frames_i};
  assign frame_next  = {1'b0, frame_cnt_q} + (WIN_W+1)'(1);
  assign window_done = sof_i && (frame_next >= win_eff);

  // The SYNC-entered SNAP only clears; an IDLE manual snap captures without any clear.
  assign capture = ((state_q == SNAP) && capture_en_q) ||
                   ((state_q == IDLE) && manual_snap_i);

  // Next-state, frame counting and capture qualification.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    capture_en_d = capture_en_q;
    case (state_q)
      IDLE: begin
        frame_cnt_d = '0;
        if (enable_i) state_d = SYNC;
      end
      SYNC: begin
        frame_cnt_d = '0;
        if (sof_i) begin
          state_d      = SNAP;
          capture_en_d = 1'b0;
        end
      end
      COUNT: begin
        if (sof_i) frame_cnt_d = frame_next[WIN_W-1:0];
        if (window_done || manual_snap_i) begin
          state_d      = SNAP;
          capture_en_d = 1'b1;
        end
      end
      SNAP: begin
        frame_cnt_d = '0;
        state_d     = COUNT;
      end
      default: state_d = IDLE;
    endcase
    if (!enable_i) state_d = IDLE;
  end

  // State register; clear is registered from the next state so it tracks SNAP exactly.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      capture_en_q <= 1'b0;
      clear_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      capture_en_q <= capture_en_d;
      clear_q      <= (state_d == SNAP);
    end
  end

  // Shadow registers take the pre-clear accumulator values at the end of the SNAP cycle.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      for (int i = 0; i < 7; i++) begin
        shadow_q[i] <= (i == 4 || i == 6) ? 32'hFFFF_FFFF : 32'h0;
      end
      snap_cnt_q <= 32'h0;
    end else if (capture) begin
      for (int i = 0; i < 7; i++) begin
        shadow_q[i] <= stat_in[i];
      end
      snap_cnt_q <= snap_cnt_q + 32'd1;
    end
  end

  // Snapshot valid/overflow; a capture wins over a coincident ack.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      snap_valid_q <= 1'b0;
      snap_ovf_q   <= 1'b0;
    end else begin
      if (capture)             snap_valid_q <= 1'b1;
      else if (bus.snap_ack_i) snap_valid_q <= 1'b0;

      if (capture && snap_valid_q && !bus.snap_ack_i) snap_ovf_q <= 1'b1;
      else if (bus.snap_ack_i)                        snap_ovf_q <= 1'b0;
    end
  end

  // Read address decode over the shadow bank and the snapshot counter.
  always_comb begin
    rd_mux = snap_cnt_q;
    case (bus.rd_addr_i)
      3'd0:    rd_mux = shadow_q[0];
      3'd1:    rd_mux = shadow_q[1];
      3'd2:    rd_mux = shadow_q[2];
      3'd3:    rd_mux = shadow_q[3];
      3'd4:    rd_mux = shadow_q[4];
      3'd5:    rd_mux = shadow_q[5];
      3'd6:    rd_mux = shadow_q[6];
      default: rd_mux = snap_cnt_q;
    endcase
  end

  // Registered read port; data holds between reads.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0;
    end else begin
      rd_valid_q <= bus.rd_en_i;
      if (bus.rd_en_i) rd_data_q <= rd_mux;
    end
  end

  assign clear_stat_o     = clear_q;
  assign bus.rd_data_o    = rd_data_q;
  assign bus.rd_valid_o   = rd_valid_q;
  assign bus.snap_valid_o = snap_valid_q;
  assign bus.snap_ovf_o   = snap_ovf_q;

endmodule
